// File: rtl/sensor_poll_scheduler_if.sv
// Read-request channel between the poll scheduler and the sensor controller.
// The scheduler (master) offers one request at a time over valid/ready and
// the controller (slave) pulses done once the response frame has gone out.
interface sensor_poll_scheduler_if;
  logic       req_valid;
  logic [7:0] req_addr;
  logic [7:0] req_cmd;
  logic       req_ready;
  logic       done;

  modport master (
    output req_valid, req_addr, req_cmd,
    input  req_ready, done
  );

  modport slave (
    input  req_valid, req_addr, req_cmd,
    output req_ready, done
  );
endinterface

// File: rtl/sensor_poll_scheduler.sv
// Round-robin poll scheduler for continuous temperature/humidity sensing.
// A 64-entry enable table ({addr, kind}) is walked one entry per cycle. Each
// hit becomes a single read request to the sensor controller. After the
// controller's done pulse, a hold-off timer keeps the shared sensor bus and
// the TX path idle before the next search starts.
// Optional macro SCHED_TIMEOUT_EN adds a WAIT_DONE watchdog. When it expires,
// the stuck entry is disabled and timeout_err pulses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no enabled entries, waiting for active_count != 0
// SEARCH    | testing the table entry at ptr, one per cycle
// ISSUE     | req_valid high, waiting for req_ready
// WAIT_DONE | request accepted, waiting for the controller's done pulse
// HOLDOFF   | down-counting SLOT_CYCLES before the next search
module sensor_poll_scheduler #(
  parameter int NUM_SENSORS    = 32,
  parameter int SLOT_CYCLES    = 130000000,
  parameter int TIMEOUT_CYCLES = 200000000
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           cmd_valid,
  input  logic [7:0]                     cmd_code,
  input  logic [7:0]                     cmd_addr,
  output logic                           cmd_ack,
  output logic                           cmd_err,
  sensor_poll_scheduler_if.master        req,
  output logic [6:0]                     active_count,
  output logic                           timeout_err
);

  localparam int         SLOT_W  = $clog2(SLOT_CYCLES + 1);
  localparam logic [8:0] NUM_LIM = 9'(NUM_SENSORS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_ISSUE,
    S_WAIT_DONE,
    S_HOLDOFF
  } state_t;

  state_t            state_q, state_d;
  logic [63:0]       en_q, en_d;
  logic [5:0]        ptr_q, ptr_d;
  logic [5:0]        miss_q, miss_d;
  logic [SLOT_W-1:0] hold_q, hold_d;
  logic [6:0]        count_q, count_d;
  logic              cmd_ack_q, cmd_ack_d;
  logic              cmd_err_q, cmd_err_d;
  logic              req_valid_q, req_valid_d;
  logic [7:0]        req_addr_q, req_addr_d;
  logic [7:0]        req_cmd_q, req_cmd_d;
  logic              cmd_ok;
  logic [5:0]        cmd_idx;

`ifdef SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] wd_q, wd_d;
  logic             tmo_q, tmo_d;
`endif

  // Codes 4..7 share the upper bits 000001. Bit 0 selects hum, bit 1 selects stop.
  assign cmd_ok  = (cmd_code[7:2] == 6'd1) && ({1'b0, cmd_addr} < NUM_LIM);
  assign cmd_idx = {cmd_addr[4:0], cmd_code[0]};

  // Popcount of the current bitmap; registered, so it trails the bitmap by one cycle.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < 64; i++) begin
      count_d = count_d + 7'(en_q[i]);
    end
  end

  // Next-state logic: the command port is served in every state, then the FSM step runs.
  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    ptr_d       = ptr_q;
    miss_d      = miss_q;
    hold_d      = hold_q;
    cmd_ack_d   = 1'b0;
    cmd_err_d   = 1'b0;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_cmd_d   = req_cmd_q;
`ifdef SCHED_TIMEOUT_EN
    wd_d        = wd_q;
    tmo_d       = 1'b0;
`endif

    if (cmd_valid) begin
      if (cmd_ok) begin
        cmd_ack_d       = 1'b1;
        en_d[cmd_idx]   = ~cmd_code[1];
      end else begin
        cmd_err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        req_valid_d = 1'b0;
        miss_d      = '0;
        if (count_q != 7'd0) state_d = S_SEARCH;
      end
      S_SEARCH: begin
        if (en_q[ptr_q]) begin
          req_addr_d  = {3'b000, ptr_q[5:1]};
          req_cmd_d   = {7'b0000010, ptr_q[0]};
          req_valid_d = 1'b1;
          miss_d      = '0;
          state_d     = S_ISSUE;
        end else begin
          ptr_d = ptr_q + 6'd1;
          // The 64th consecutive miss means a full lap found nothing enabled.
          if (miss_q == 6'd63) begin
            miss_d  = '0;
            state_d = S_IDLE;
          end else begin
            miss_d = miss_q + 6'd1;
          end
        end
      end
      S_ISSUE: begin
        // A completed handshake takes priority over a stop seen in the same cycle.
        if (req_valid_q && req.req_ready) begin
          req_valid_d = 1'b0;
          state_d     = S_WAIT_DONE;
`ifdef SCHED_TIMEOUT_EN
          wd_d        = TMO_W'(TIMEOUT_CYCLES - 1);
`endif
        end else if (!en_q[ptr_q]) begin
          req_valid_d = 1'b0;
          ptr_d       = ptr_q + 6'd1;
          state_d     = S_SEARCH;
        end
      end
      S_WAIT_DONE: begin
        req_valid_d = 1'b0;
        if (req.done) begin
          ptr_d   = ptr_q + 6'd1;
          hold_d  = SLOT_W'(SLOT_CYCLES - 1);
          state_d = S_HOLDOFF;
`ifdef SCHED_TIMEOUT_EN
        end else if (wd_q == '0) begin
          en_d[ptr_q] = 1'b0;
          tmo_d       = 1'b1;
          ptr_d       = ptr_q + 6'd1;
          hold_d      = SLOT_W'(SLOT_CYCLES - 1);
          state_d     = S_HOLDOFF;
        end else begin
          wd_d = wd_q - TMO_W'(1);
`endif
        end
      end
      S_HOLDOFF: begin
        miss_d = '0;
        if (hold_q == '0) state_d = S_SEARCH;
        else              hold_d  = hold_q - SLOT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      en_q        <= '0;
      ptr_q       <= '0;
      miss_q      <= '0;
      hold_q      <= '0;
      count_q     <= '0;
      cmd_ack_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_cmd_q   <= '0;
`ifdef SCHED_TIMEOUT_EN
      wd_q        <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      ptr_q       <= ptr_d;
      miss_q      <= miss_d;
      hold_q      <= hold_d;
      count_q     <= count_d;
      cmd_ack_q   <= cmd_ack_d;
      cmd_err_q   <= cmd_err_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_cmd_q   <= req_cmd_d;
`ifdef SCHED_TIMEOUT_EN
      wd_q        <= wd_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign cmd_ack       = cmd_ack_q;
  assign cmd_err       = cmd_err_q;
  assign active_count  = count_q;
  assign req.req_valid = req_valid_q;
  assign req.req_addr  = req_addr_q;
  assign req.req_cmd   = req_cmd_q;

`ifdef SCHED_TIMEOUT_EN
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Bench for sensor_poll_scheduler with SLOT_CYCLES=10 and TIMEOUT_CYCLES=50.
// The expected request sequence is queued when the enables are driven.
// A negedge monitor pops the queue and compares it at every req handshake.
module tb_sensor_poll_scheduler;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_code = 8'd0;
  logic [7:0] cmd_addr = 8'd0;
  logic       cmd_ack;
  logic       cmd_err;
  logic [6:0] active_count;
  logic       timeout_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [15:0] exp_q[$];
  logic [15:0] sb_exp;

  sensor_poll_scheduler_if rif();

  sensor_poll_scheduler #(
    .NUM_SENSORS   (32),
    .SLOT_CYCLES   (10),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .cmd_addr    (cmd_addr),
    .cmd_ack     (cmd_ack),
    .cmd_err     (cmd_err),
    .req         (rif),
    .active_count(active_count),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard monitor: every accepted request must match the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && rif.req_valid && rif.req_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got addr=%0d cmd=%0d, required no request", rif.req_addr, rif.req_cmd);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({rif.req_addr, rif.req_cmd} !== sb_exp) begin
          errors++;
          $display("FAIL sb_request: got addr=%0d cmd=%0d, required addr=%0d cmd=%0d",
                   rif.req_addr, rif.req_cmd, sb_exp[15:8], sb_exp[7:0]);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic apply_reset();
    cmd_valid     = 1'b0;
    rif.req_ready = 1'b0;
    rif.done      = 1'b0;
    reset_n       = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    exp_q.delete();
  endtask

  task automatic send_cmd(input logic [7:0] code, input logic [7:0] addr);
    cmd_valid = 1'b1;
    cmd_code  = code;
    cmd_addr  = addr;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req(output int waited);
    waited = 0;
    while (!rif.req_valid && waited < 500) begin
      tick(1);
      waited++;
    end
    if (!rif.req_valid) begin
      checks++;
      errors++;
      $display("FAIL req_wait: req_valid=%0b after %0d cycles, required 1", rif.req_valid, waited);
    end
  endtask

  task automatic handshake();
    rif.req_ready = 1'b1;
    tick(1);
    rif.req_ready = 1'b0;
  endtask

  task automatic pulse_done();
    rif.done = 1'b1;
    tick(1);
    rif.done = 1'b0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    cmd_valid = 1'b1;
    cmd_code  = 8'd4;
    cmd_addr  = 8'd1;
    tick(2);
    checks++;
    if ({cmd_ack, cmd_err, rif.req_valid, timeout_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0000", {cmd_ack, cmd_err, rif.req_valid, timeout_err});
    end
    checks++;
    if ({rif.req_addr, rif.req_cmd} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_req_bus: got %h, required 0000", {rif.req_addr, rif.req_cmd});
    end
    checks++;
    if (active_count !== 7'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d, required 0", active_count);
    end
    cmd_valid = 1'b0;
    reset_n   = 1'b1;
    tick(1);
  endtask

  task automatic test_single();
    int w;
    apply_reset();
    send_cmd(8'd4, 8'd3);
    checks++;
    if ({cmd_ack, cmd_err} !== 2'b10) begin
      errors++;
      $display("FAIL single_ack: got ack,err=%b, required 10", {cmd_ack, cmd_err});
    end
    exp_q.push_back({8'd3, 8'd4});
    exp_q.push_back({8'd3, 8'd4});
    wait_req(w);
    checks++;
    if ({rif.req_addr, rif.req_cmd} !== {8'd3, 8'd4}) begin
      errors++;
      $display("FAIL single_req: got addr=%0d cmd=%0d, required addr=3 cmd=4", rif.req_addr, rif.req_cmd);
    end
    handshake();
    tick(3);
    pulse_done();
    // 10 hold-off cycles plus a 64-entry lap (63 misses, hit on the same entry).
    wait_req(w);
    checks++;
    if (w !== 74) begin
      errors++;
      $display("FAIL single_repeat_gap: got %0d cycles, required 74", w);
    end
    handshake();
    tick(2);
    pulse_done();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL single_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int w;
    apply_reset();
    send_cmd(8'd4, 8'd3);
    send_cmd(8'd5, 8'd3);
    send_cmd(8'd4, 8'd17);
    checks++;
    if (cmd_ack !== 1'b1) begin
      errors++;
      $display("FAIL rot_ack: got %b, required 1", cmd_ack);
    end
    exp_q.push_back({8'd3, 8'd4});
    exp_q.push_back({8'd3, 8'd5});
    exp_q.push_back({8'd17, 8'd4});
    exp_q.push_back({8'd3, 8'd4});
    for (int i = 0; i < 4; i++) begin
      wait_req(w);
      handshake();
      tick(2);
      pulse_done();
    end
    checks++;
    if (active_count !== 7'd3) begin
      errors++;
      $display("FAIL rot_count: got %0d, required 3", active_count);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL rot_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_stop_inflight();
    int w;
    apply_reset();
    send_cmd(8'd4, 8'd3);
    send_cmd(8'd5, 8'd3);
    send_cmd(8'd4, 8'd17);
    exp_q.push_back({8'd3, 8'd4});
    wait_req(w);
    handshake();
    checks++;
    if (active_count !== 7'd3) begin
      errors++;
      $display("FAIL stop_count_before: got %0d, required 3", active_count);
    end
    send_cmd(8'd6, 8'd3);
    checks++;
    if ({cmd_ack, cmd_err} !== 2'b10) begin
      errors++;
      $display("FAIL stop_ack: got ack,err=%b, required 10", {cmd_ack, cmd_err});
    end
    tick(2);
    checks++;
    if (active_count !== 7'd2) begin
      errors++;
      $display("FAIL stop_count_after: got %0d, required 2", active_count);
    end
    checks++;
    if (rif.req_valid !== 1'b0) begin
      errors++;
      $display("FAIL stop_inflight_valid: got %b, required 0", rif.req_valid);
    end
    pulse_done();
    exp_q.push_back({8'd3, 8'd5});
    exp_q.push_back({8'd17, 8'd4});
    exp_q.push_back({8'd3, 8'd5});
    for (int i = 0; i < 3; i++) begin
      wait_req(w);
      handshake();
      tick(2);
      pulse_done();
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL stop_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_invalid();
    apply_reset();
    send_cmd(8'd9, 8'd2);
    checks++;
    if ({cmd_ack, cmd_err} !== 2'b01) begin
      errors++;
      $display("FAIL inv_code: got ack,err=%b, required 01", {cmd_ack, cmd_err});
    end
    send_cmd(8'd4, 8'd40);
    checks++;
    if ({cmd_ack, cmd_err} !== 2'b01) begin
      errors++;
      $display("FAIL inv_addr40: got ack,err=%b, required 01", {cmd_ack, cmd_err});
    end
    send_cmd(8'd4, 8'd32);
    checks++;
    if ({cmd_ack, cmd_err} !== 2'b01) begin
      errors++;
      $display("FAIL inv_addr32: got ack,err=%b, required 01", {cmd_ack, cmd_err});
    end
    tick(3);
    checks++;
    if ({rif.req_valid, active_count} !== 8'd0) begin
      errors++;
      $display("FAIL inv_no_change: got valid=%b count=%0d, required 0 0", rif.req_valid, active_count);
    end
    send_cmd(8'd4, 8'd31);
    checks++;
    if ({cmd_ack, cmd_err} !== 2'b10) begin
      errors++;
      $display("FAIL edge_addr31: got ack,err=%b, required 10", {cmd_ack, cmd_err});
    end
    send_cmd(8'd4, 8'd31);
    send_cmd(8'd7, 8'd31);
    checks++;
    if ({cmd_ack, cmd_err} !== 2'b10) begin
      errors++;
      $display("FAIL clear_clear_ack: got ack,err=%b, required 10", {cmd_ack, cmd_err});
    end
    tick(2);
    checks++;
    if (active_count !== 7'd1) begin
      errors++;
      $display("FAIL dup_count: got %0d, required 1", active_count);
    end
    send_cmd(8'd6, 8'd31);
    tick(80);
    checks++;
    if ({rif.req_valid, active_count} !== 8'd0) begin
      errors++;
      $display("FAIL drop_issue: got valid=%b count=%0d, required 0 0", rif.req_valid, active_count);
    end
  endtask

  task automatic test_stall_reset();
    int w;
    apply_reset();
    send_cmd(8'd5, 8'd10);
    wait_req(w);
    for (int i = 0; i < 20; i++) begin
      rif.done = (i == 10);
      checks++;
      if ({rif.req_valid, rif.req_addr, rif.req_cmd} !== {1'b1, 8'd10, 8'd5}) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got valid=%b addr=%0d cmd=%0d, required 1 10 5",
                 i, rif.req_valid, rif.req_addr, rif.req_cmd);
      end
      tick(1);
    end
    rif.done = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL stall_timeout_err: got %b, required 0", timeout_err);
    end
    reset_n = 1'b0;
    tick(1);
    checks++;
    if ({rif.req_valid, active_count} !== 8'd0) begin
      errors++;
      $display("FAIL stall_reset: got valid=%b count=%0d, required 0 0", rif.req_valid, active_count);
    end
    reset_n = 1'b1;
    tick(20);
    checks++;
    if (rif.req_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got valid=%b, required 0", rif.req_valid);
    end
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int w;
    int n;
    apply_reset();
    send_cmd(8'd4, 8'd3);
    exp_q.push_back({8'd3, 8'd4});
    wait_req(w);
    handshake();
    n = 0;
    while (!timeout_err && n < 200) begin
      tick(1);
      n++;
    end
    checks++;
    if (n !== 50) begin
      errors++;
      $display("FAIL timeout_cycle: got %0d, required 50", n);
    end
    tick(1);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got %b, required 0", timeout_err);
    end
    tick(2);
    checks++;
    if (active_count !== 7'd0) begin
      errors++;
      $display("FAIL timeout_cleared: got %0d, required 0", active_count);
    end
    tick(150);
    checks++;
    if (rif.req_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: got valid=%b, required 0", rif.req_valid);
    end
  endtask
`endif

  initial begin
    rif.req_ready = 1'b0;
    rif.done      = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stop_inflight();
    test_invalid();
    test_stall_reset();
`ifdef SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sensor_poll_scheduler.md
Name: sensor_poll_scheduler

Overview:
- Round-robin scheduler for continuous sensing (commands 4/5) across up to 32 sensor addresses, each with temperature and humidity channels.
- Holds a per-address enable bitmap, updated from decoded UART requests.
- Issues one read request at a time to the sensor controller FSM over a valid/ready handshake, then waits for its done pulse.
- Enforces a minimum hold-off between consecutive reads, so the shared single-wire sensor bus and TX path are never overlapped.

Parameters:
- NUM_SENSORS, 32, number of addressable sensors; valid addresses are 0..NUM_SENSORS-1.
- SLOT_CYCLES, 130000000, hold-off clock cycles between a done pulse and the next search.
- TIMEOUT_CYCLES, 200000000, WAIT_DONE watchdog limit; used only when SCHED_TIMEOUT_EN is defined.

Ports:
- clock  in  1  50 MHz board clock.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  one-cycle pulse; a new decoded request is present.
- cmd_code  in  8  4 = start temp, 5 = start hum, 6 = stop temp, 7 = stop hum.
- cmd_addr  in  8  target sensor address.
- cmd_ack  out  1  one-cycle pulse; command accepted.
- cmd_err  out  1  one-cycle pulse; code not 4..7, or cmd_addr >= NUM_SENSORS.
- req_valid  out  1  read request pending to the sensor controller.
- req_addr  out  8  address of the pending request; upper bits are zero.
- req_cmd  out  8  4 (temp) or 5 (hum).
- req_ready  in  1  controller idle; handshake completes when req_valid & req_ready.
- done  in  1  one-cycle pulse; controller has sent the response frame.
- active_count  out  7  number of set enable bits (0..64).
- timeout_err  out  1  one-cycle pulse; watchdog expired (feature only, otherwise tied 0).

Behaviour:
- Reset (reset_n = 0 at a clock edge):
  - All enable bits, counters and ptr cleared; state = IDLE.
  - All outputs are 0, including a req_valid that is mid-handshake.
- Schedule table: 2*NUM_SENSORS entries. ptr[5:0] indexes it; ptr[0] = kind (0 temp, 1 hum), ptr[5:1] = address.
- Command port, evaluated every cycle in every state:
  - Valid command: cmd_ack on the next cycle.
  - Codes 4/5 set the entry's enable bit; codes 6/7 clear it.
  - Setting an already-set bit, or clearing an already-clear bit, is still acked with no change.
  - Invalid command: cmd_err on the next cycle; no state change.
- active_count is the registered popcount of the enable bits, valid 1 cycle after any change.
- IDLE:
  - req_valid = 0.
  - Go to SEARCH when active_count != 0.
- SEARCH:
  - Tests one entry per cycle, starting at ptr.
  - Enabled entry: latch req_addr/req_cmd and go to ISSUE.
  - Disabled entry: ptr increments, wrapping 63 -> 0.
  - After 64 consecutive misses (all bits cleared meanwhile), go to IDLE.
  - Enable bits are read live, so a stop arriving during the search is honoured.
- ISSUE:
  - req_valid = 1, with req_addr/req_cmd held stable until req_ready.
  - On the handshake cycle, go to WAIT_DONE.
  - If the entry is disabled while still in ISSUE, drop req_valid next cycle and return to SEARCH at ptr+1.
- WAIT_DONE:
  - req_valid = 0; wait for done.
  - A stop for the in-flight entry does not abort it; the read completes, then the entry is skipped afterwards.
  - On done, set ptr = ptr+1 (wrapping), load the hold-off counter, go to HOLDOFF.
- HOLDOFF:
  - Count SLOT_CYCLES cycles, then go to SEARCH.
  - A done pulse outside WAIT_DONE is ignored.
- Fairness: two active entries alternate; a single active entry repeats every (latency + SLOT_CYCLES + search) cycles.

Optional Feature:
- Macro: SCHED_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in WAIT_DONE.
  - On reaching TIMEOUT_CYCLES without done: clear that entry's enable bit, pulse timeout_err, advance ptr, go to HOLDOFF.
  - done and expiry in the same cycle: done wins, no error.
- Undefined:
  - No watchdog; WAIT_DONE waits indefinitely.
  - timeout_err is constant 0.

Test Plan:
- SLOT_CYCLES = 10; cmd 4 @ addr 3 -> cmd_ack next cycle; req_valid with req_addr = 3, req_cmd = 4; req_ready = 1 -> WAIT_DONE; done -> 10-cycle gap, then the same request repeats.
- Enable 4@3, 5@3 and 4@17 -> requests rotate (3,4), (3,5), (17,4), (3,4)...; active_count = 3.
- Stop 6@3 while (3,4) is in WAIT_DONE -> that read completes; (3,4) is never requested again; active_count drops 3 -> 2.
- cmd 9@2 and cmd 4@40 -> cmd_err pulses, no cmd_ack, bitmap unchanged, active_count = 0.
- Hold req_ready = 0 for 20 cycles -> req_valid, req_addr and req_cmd stay stable; assert reset_n = 0 for 1 cycle mid-ISSUE -> req_valid = 0 and active_count = 0 next cycle.
- SCHED_TIMEOUT_EN with TIMEOUT_CYCLES = 50, done never asserted -> timeout_err at cycle 50 of WAIT_DONE, entry cleared, scheduler returns to IDLE once no entries remain.
